// File: rtl/p2s_pkg.sv
// rtl/p2s_pkg.sv - shared widths and state encoding for the p2s transmitter and s2p receiver
package p2s_pkg;

  localparam int DATA_W = 14;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DATA_W);

endpackage

// File: rtl/p2s_tx.sv
// rtl/p2s_tx.sv - parallel-to-serial transmitter with frame marker and one-word holding buffer
module p2s_tx
  import p2s_pkg::*;
#(
  parameter int WIDTH     = DATA_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame,
  output logic             done
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             frame_q, frame_d;

  logic             xfer;
  logic             last_bit;
  logic             load;
  logic [WIDTH-1:0] load_src;

  assign din_ready  = en & ~hold_full_q;
  assign xfer       = din_valid & din_ready;
  assign last_bit   = (cnt_q == LAST);
  // A pending buffered word always wins over a fresh offer; in IDLE the buffer is empty
  assign load_src   = hold_full_q ? hold_q : din;

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign frame      = frame_q;
  assign done       = en & dv_q & (state_q == SHIFT) & last_bit;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    dout_d      = dout_q;
    dv_d        = dv_q;
    frame_d     = frame_q;
    load        = 1'b0;

    if (en) begin
      case (state_q)
        IDLE: begin
          load = xfer;
        end
        SHIFT: begin
          if (last_bit) begin
            if (hold_full_q || xfer) begin
              load        = 1'b1;
              hold_full_d = 1'b0;
            end else begin
              state_d = IDLE;
              dout_d  = 1'b0;
              dv_d    = 1'b0;
              frame_d = 1'b0;
            end
          end else begin
            cnt_d   = cnt_q + CW'(1);
            dout_d  = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
            sreg_d  = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
            frame_d = 1'b0;
            if (xfer) begin
              hold_d      = din;
              hold_full_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (load) begin
        state_d = SHIFT;
        cnt_d   = '0;
        dv_d    = 1'b1;
        frame_d = 1'b1;
        dout_d  = MSB_FIRST ? load_src[WIDTH-1] : load_src[0];
        sreg_d  = MSB_FIRST ? {load_src[WIDTH-2:0], 1'b0} : {1'b0, load_src[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      dout_q      <= 1'b0;
      dv_q        <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      dout_q      <= dout_d;
      dv_q        <= dv_d;
      frame_q     <= frame_d;
    end
  end

endmodule

// File: tb/tb_p2s_tx.sv
// tb/tb_p2s_tx.sv - randomized and directed bench for p2s_tx against a bit-queue reference model
module tb_p2s_tx;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] din;
  logic         din_valid;
  logic         rdy_m, dout_m, dv_m, frame_m, done_m;
  logic         rdy_l, dout_l, dv_l, frame_l, done_l;

  int checks = 0;
  int errors = 0;

  p2s_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .dout(dout_m), .dout_valid(dv_m), .frame(frame_m), .done(done_m)
  );

  p2s_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .dout(dout_l), .dout_valid(dv_l), .frame(frame_l), .done(done_l)
  );

  always #5 clk = ~clk;

  // One record per serial bit still to be sent; both bit orders tracked side by side
  typedef struct packed {
    logic valid;
    logic bm;
    logic bl;
    logic first;
    logic last;
  } rec_t;

  rec_t q[$];
  rec_t cur = '0;
  logic last_xfer = 1'b0;
  logic rand_en = 1'b0;

  function automatic logic word_waiting();
    foreach (q[i]) if (q[i].first) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic er;
    er = en & ~word_waiting();
    chk("din_ready_msb", rdy_m, er);
    chk("din_ready_lsb", rdy_l, er);
    chk("dout_msb", dout_m, cur.valid & cur.bm);
    chk("dout_lsb", dout_l, cur.valid & cur.bl);
    chk("dout_valid_msb", dv_m, cur.valid);
    chk("dout_valid_lsb", dv_l, cur.valid);
    chk("frame_msb", frame_m, cur.valid & cur.first);
    chk("frame_lsb", frame_l, cur.valid & cur.first);
    chk("done_msb", done_m, cur.valid & cur.last & en);
    chk("done_lsb", done_l, cur.valid & cur.last & en);
  endtask

  task automatic push_word(input logic [W-1:0] w);
    rec_t r;
    for (int k = 0; k < W; k++) begin
      r.valid = 1'b1;
      r.bm    = w[W-1-k];
      r.bl    = w[k];
      r.first = (k == 0);
      r.last  = (k == W - 1);
      q.push_back(r);
    end
  endtask

  task automatic step();
    logic x;
    if (rand_en) en = ($urandom_range(0, 4) != 0);
    x = 1'b0;
    @(posedge clk);
    if (!rst && en) begin
      x = din_valid & ~word_waiting();
      if (x) push_word(din);
      if (q.size() > 0) cur = q.pop_front();
      else cur = '0;
    end
    last_xfer = x;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_word(input logic [W-1:0] w);
    int n;
    din       = w;
    din_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_xfer && n < 80);
    checks++;
    if (!last_xfer) begin
      errors++;
      $error("FAIL send_timeout: word %h not accepted after %0d cycles, expected acceptance", w, n);
    end
    din_valid = 1'b0;
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    q.delete();
    cur = '0;
    check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] cap_m, cap_l;
    logic [W-1:0] exp_cap;
    rst       = 1'b1;
    en        = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // single word, captured as a stream and compared with the literal pattern
    send_word(14'h2D35);
    cap_m = '0;
    cap_l = '0;
    for (int i = 0; i < W; i++) begin
      cap_m = {cap_m[W-2:0], dout_m};
      cap_l = {dout_l, cap_l[W-1:1]};
      step();
    end
    exp_cap = 14'b10110100110101;
    checks++;
    assert (cap_m === exp_cap) else begin
      errors++;
      $error("FAIL stream_msb: got %b, expected %b", cap_m, exp_cap);
    end
    checks++;
    assert (cap_l === exp_cap) else begin
      errors++;
      $error("FAIL stream_lsb: got %b, expected %b", cap_l, exp_cap);
    end
    idle(3);

    // back-to-back through the holding buffer
    send_word(14'h3FFF);
    send_word(14'h0001);
    idle(30);

    // stall after bit 5
    send_word(14'h2D35);
    idle(4);
    en = 1'b0;
    idle(3);
    en = 1'b1;
    idle(16);

    // reset mid-word with a buffered word pending
    send_word(14'h1555);
    send_word(14'h2AAA);
    idle(6);
    async_reset();
    idle(20);

    // offer held while buffer is full
    send_word(14'h1234);
    send_word(14'h0F0F);
    send_word(14'h3C3C);
    idle(45);

    // small value to exercise LSB-first ordering
    send_word(14'h0003);
    idle(16);

    // randomized traffic with random stalls and gaps
    rand_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_word(W'($urandom));
      idle($urandom_range(0, 3) * ($urandom_range(0, 2) == 0 ? 4 : 0));
    end
    idle(60);
    rand_en = 1'b0;
    en = 1'b1;
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/p2s_tx.md
Name: p2s_tx

Overview:
- Parallel-to-serial transmitter; the transmit-side counterpart of the s2p serial receiver.
- Takes the 14-bit signed result word of the divide/sine/multiply datapath over a valid/ready handshake.
- Shifts the word out MSB-first on a single serial line, with a frame-start marker so a downstream s2p-style receiver can realign.
- A one-entry holding buffer allows back-to-back words with no idle gap.

Parameters:
- WIDTH, 14, bits per serial word (matches y width).
- MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  clock enable; when 0, the block is fully stalled.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  block can accept din this cycle.
- dout  output  1  serial data bit (registered).
- dout_valid  output  1  dout carries a data bit this cycle.
- frame  output  1  high during the first bit of each word.
- done  output  1  one-cycle pulse during the last bit of each word.

Behaviour:
- Reset (async, rst=1): state=IDLE, shift reg=0, bit counter=0, hold buffer empty; dout=0, dout_valid=0, frame=0, done=0.
- din_ready is combinational: en & ~hold_full. It is 1 after reset when en=1.
- Transfer occurs on a rising clk edge with din_valid & din_ready.
- State IDLE (no word shifting):
  - On transfer, din loads the shift register and the counter is cleared; go to SHIFT.
  - dout_valid=1 and frame=1 for the next cycle. Latency from accept edge to first bit is 1 cycle.
- State SHIFT:
  - Each cycle with en=1 advances one bit: dout = current bit, counter +1.
  - A transfer in SHIFT writes the hold buffer (hold_full=1).
  - On the edge that ends bit WIDTH-1:
    - If hold_full: buffer moves to the shift register, counter=0, hold_full=0, frame=1 next cycle. No gap.
    - Else if transfer this edge: din loads the shift register directly. No gap.
    - Else: go to IDLE; dout_valid=0, dout=0.
- done=1 exactly in the cycle dout carries bit WIDTH-1 (and en=1).
- frame and done never assert in the same cycle (WIDTH>1).
- Stall, en=0:
  - Counter, shift register, buffer and state are frozen.
  - dout, dout_valid and frame hold their values; done is forced 0.
  - din_ready=0.
- Bit order:
  - MSB_FIRST=1: bit k of the frame is din[WIDTH-1-k].
  - MSB_FIRST=0: bit k of the frame is din[k].
- din content is never modified. Sign/two's-complement interpretation is the receiver's concern.
- rst mid-word aborts the word immediately: no done pulse, buffered word discarded.
- din_valid while din_ready=0 is ignored. The source must hold din/din_valid until the transfer.
- Throughput: one word per WIDTH enabled cycles sustained.

Decomposition:
- Shared package p2s_pkg:
  - Localparam DATA_W=14.
  - State encoding IDLE/SHIFT.
  - Counter width CNT_W = clog2(WIDTH).
- Reuse DATA_W in the s2p receiver for width agreement.
- No sub-module needed. The hold buffer and shift/counter core stay in one module; the target is about 150 lines.

Test Plan:
- Reset, en=1, din=14'h2D35 valid for one cycle.
  - dout over the next 14 cycles is 1,0,1,1,0,1,0,0,1,1,0,1,0,1.
  - frame=1 on cycle 1 only; done=1 on cycle 14; dout_valid=0 on cycle 15.
- Back-to-back: send 14'h3FFF, then 14'h0001 while the first is shifting.
  - 28 contiguous valid bits: fourteen 1s, then thirteen 0s and a 1.
  - frame at bits 1 and 15; din_ready=0 while the buffer is full.
- Stall: en=0 for 3 cycles after bit 5 of 14'h2D35.
  - dout holds bit 5 value (1); counter frozen; no done.
  - Stream resumes with bit 6=0; done is 3 cycles later than nominal.
- Reset mid-word: rst pulse during bit 7 with a buffered word pending.
  - All outputs 0 asynchronously; no done; din_ready=1 after release; buffered word never appears.
- Offer while full: din_valid held with buffer full.
  - No transfer until the buffer drains at the word boundary; the held word is transmitted exactly once.
- MSB_FIRST=0, din=14'h0003.
  - Bits out are 1,1 followed by twelve 0s.
